// File: rtl/l2c_pkg.sv
// rtl/l2c_pkg.sv - shared constants for the L2C writeback-ack path
package l2c_pkg;

  localparam int L2C_WB_ADDR_W    = 32;
  localparam int L2C_WB_ACK_DEPTH = 4;
  localparam int L2C_WB_MAX_OUT   = 8;

  // o_err bit positions
  localparam int L2C_WB_ERR_W     = 2;
  localparam int L2C_WB_ERR_OVF   = 1;  // issue while already at MAX_OUT
  localparam int L2C_WB_ERR_UNEXP = 0;  // pop while nothing outstanding

endpackage

// File: rtl/l2c_wb_fifo.sv
// rtl/l2c_wb_fifo.sv - generic synchronous FIFO with occupancy, full and empty
module l2c_wb_fifo
  import l2c_pkg::*;
#(
  parameter int DEPTH = L2C_WB_ACK_DEPTH,
  parameter int W     = L2C_WB_ADDR_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty come straight off the occupancy register; a pop never frees
  // a slot for a push in the same cycle.
  assign full_o  = (cnt_q == OCC_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Next pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy state; cleared by reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write; contents are left unreset, validity comes from cnt_q.
  always_ff @(posedge Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/l2c_wb_ack_queue.sv
// rtl/l2c_wb_ack_queue.sv - writeback-ack buffer and outstanding counter; optional checks under L2C_WB_ACK_CHK_EN
module l2c_wb_ack_queue
  import l2c_pkg::*;
#(
  parameter int DEPTH   = L2C_WB_ACK_DEPTH,
  parameter int ADDR_W  = L2C_WB_ADDR_W,
  parameter int MAX_OUT = L2C_WB_MAX_OUT,
  parameter int CNT_W   = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_wb_issue,
  input  logic              i_ack_valid,
  input  logic [ADDR_W-1:0] i_ack_addr,
  output logic              o_ack_stall,
  output logic              o_ack_valid,
  output logic [ADDR_W-1:0] o_ack_addr,
  input  logic              i_ack_stall,
  output logic [CNT_W-1:0]  o_outstanding,
  output logic              o_wb_full,
  output logic              o_idle
`ifdef L2C_WB_ACK_CHK_EN
  ,
  output logic [L2C_WB_ERR_W-1:0] o_err
`endif
);

  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic [CNT_W-1:0] out_q, out_d;
  logic             out_at_max;
  logic             out_at_zero;

  l2c_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (ADDR_W)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .push_i  (i_ack_valid),
    .wdata_i (i_ack_addr),
    .pop_i   (pop),
    .rdata_o (o_ack_addr),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The writeback retires when the downstream FSM consumes the head.
  assign pop           = ~fifo_empty & ~i_ack_stall;
  assign out_at_max    = (out_q == CNT_W'(MAX_OUT));
  assign out_at_zero   = (out_q == '0);

  assign o_ack_stall   = fifo_full;
  assign o_ack_valid   = ~fifo_empty;
  assign o_outstanding = out_q;
  assign o_wb_full     = out_at_max;
  assign o_idle        = fifo_empty & out_at_zero;

  // Outstanding count saturates at both ends; issue and pop together cancel.
  always_comb begin
    out_d = out_q;
    if (i_wb_issue && !pop && !out_at_max)  out_d = out_q + 1'b1;
    if (pop && !i_wb_issue && !out_at_zero) out_d = out_q - 1'b1;
  end

  // Outstanding counter register.
  always_ff @(posedge Clk) begin
    if (Reset) out_q <= '0;
    else       out_q <= out_d;
  end

`ifdef L2C_WB_ACK_CHK_EN
  logic [L2C_WB_ERR_W-1:0] err_q;

  assign o_err = err_q;

  // Sticky protocol errors, cleared only by reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      err_q <= '0;
    end else begin
      if (i_wb_issue && out_at_max) err_q[L2C_WB_ERR_OVF]   <= 1'b1;
      if (pop && out_at_zero)       err_q[L2C_WB_ERR_UNEXP] <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Simulation report of each protocol error as it happens.
  always_ff @(posedge Clk) begin
    if (!Reset && i_wb_issue && out_at_max)
      $display("l2c_wb_ack_queue: writeback issued with %0d already outstanding", MAX_OUT);
    if (!Reset && pop && out_at_zero)
      $display("l2c_wb_ack_queue: ack 0x%0h consumed with no writeback outstanding", o_ack_addr);
  end
`endif
`endif

endmodule

// File: tb/tb_l2c_wb_ack_queue.sv
// tb/tb_l2c_wb_ack_queue.sv - self-checking bench for l2c_wb_ack_queue
module tb_l2c_wb_ack_queue;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 32;
  localparam int MAX_OUT = 8;
  localparam int CNT_W   = 4;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              i_wb_issue = 1'b0;
  logic              i_ack_valid = 1'b0;
  logic [ADDR_W-1:0] i_ack_addr = '0;
  logic              i_ack_stall = 1'b1;
  logic              o_ack_stall;
  logic              o_ack_valid;
  logic [ADDR_W-1:0] o_ack_addr;
  logic [CNT_W-1:0]  o_outstanding;
  logic              o_wb_full;
  logic              o_idle;
`ifdef L2C_WB_ACK_CHK_EN
  logic [1:0]        o_err;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [ADDR_W-1:0] m_q[$];
  int                m_out = 0;
  logic [1:0]        m_err = 2'b00;
  bit                model_live = 1'b0;

  l2c_wb_ack_queue #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .MAX_OUT (MAX_OUT),
    .CNT_W   (CNT_W)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .i_wb_issue    (i_wb_issue),
    .i_ack_valid   (i_ack_valid),
    .i_ack_addr    (i_ack_addr),
    .o_ack_stall   (o_ack_stall),
    .o_ack_valid   (o_ack_valid),
    .o_ack_addr    (o_ack_addr),
    .i_ack_stall   (i_ack_stall),
    .o_outstanding (o_outstanding),
    .o_wb_full     (o_wb_full),
    .o_idle        (o_idle)
`ifdef L2C_WB_ACK_CHK_EN
    ,
    .o_err         (o_err)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    i_wb_issue = 1'b0;
    i_ack_valid = 1'b0;
    step();
    Reset = 1'b0;
  endtask

  // model: a queue of accepted addresses and an integer outstanding count
  always @(posedge Clk) begin
    bit push;
    bit pop;
    if (Reset) begin
      m_q.delete();
      m_out = 0;
      m_err = 2'b00;
      model_live = 1'b1;
    end else begin
      pop  = (m_q.size() != 0) && !i_ack_stall;
      push = i_ack_valid && (m_q.size() < DEPTH);
      if (i_wb_issue && m_out == MAX_OUT) m_err[1] = 1'b1;
      if (pop && m_out == 0)              m_err[0] = 1'b1;
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(i_ack_addr);
      if (i_wb_issue && !pop) begin
        if (m_out < MAX_OUT) m_out++;
      end else if (pop && !i_wb_issue) begin
        if (m_out > 0) m_out--;
      end
    end
  end

  // every-cycle comparison against the model, mid-cycle
  always @(negedge Clk) begin
    if (model_live) begin
      chk("m_valid", {31'd0, o_ack_valid}, {31'd0, m_q.size() != 0});
      chk("m_stall", {31'd0, o_ack_stall}, {31'd0, m_q.size() == DEPTH});
      if (m_q.size() != 0) chk("m_addr", o_ack_addr, m_q[0]);
      chk("m_out", {28'd0, o_outstanding}, 32'(m_out));
      chk("m_full", {31'd0, o_wb_full}, {31'd0, m_out == MAX_OUT});
      chk("m_idle", {31'd0, o_idle}, {31'd0, (m_q.size() == 0) && (m_out == 0)});
`ifdef L2C_WB_ACK_CHK_EN
      chk("m_err", {30'd0, o_err}, {30'd0, m_err});
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [ADDR_W-1:0] got[$];
    logic [ADDR_W-1:0] exp5[5];
    bit pending;
    bit accept_now;
    exp5 = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};

    // reset state
    step();
    step();
    chk("rst_valid", {31'd0, o_ack_valid}, 32'd0);
    chk("rst_stall", {31'd0, o_ack_stall}, 32'd0);
    chk("rst_idle",  {31'd0, o_idle}, 32'd1);
    chk("rst_out",   {28'd0, o_outstanding}, 32'd0);
    chk("rst_full",  {31'd0, o_wb_full}, 32'd0);
    Reset = 1'b0;

    // single ack held by a 3-cycle downstream stall
    i_ack_stall = 1'b1;
    i_ack_valid = 1'b1;
    i_ack_addr  = 32'h1000;
    step();
    i_ack_valid = 1'b0;
    chk("t1_valid", {31'd0, o_ack_valid}, 32'd1);
    chk("t1_addr", o_ack_addr, 32'h1000);
    step();
    step();
    chk("t1_hold_addr", o_ack_addr, 32'h1000);
    chk("t1_hold_valid", {31'd0, o_ack_valid}, 32'd1);
    i_ack_stall = 1'b0;
    step();
    chk("t1_popped", {31'd0, o_ack_valid}, 32'd0);
    i_ack_stall = 1'b1;

    // five acks into a four-entry queue, then drain in order
    do_reset();
    for (int i = 0; i < 4; i++) begin
      i_ack_valid = 1'b1;
      i_ack_addr  = 32'hA0 + 32'(i);
      step();
    end
    chk("t2_full_stall", {31'd0, o_ack_stall}, 32'd1);
    chk("t2_head", o_ack_addr, 32'hA0);
    i_ack_addr = 32'hA4;
    step();
    step();
    chk("t2_still_stall", {31'd0, o_ack_stall}, 32'd1);
    i_ack_stall = 1'b0;
    pending = 1'b1;
    for (int c = 0; c < 12; c++) begin
      accept_now = pending && !o_ack_stall;
      if (o_ack_valid) got.push_back(o_ack_addr);
      step();
      if (c == 0) begin
        chk("t3_stall_drop", {31'd0, o_ack_stall}, 32'd0);
        chk("t3_valid", {31'd0, o_ack_valid}, 32'd1);
      end
      if (accept_now) begin
        pending = 1'b0;
        i_ack_valid = 1'b0;
      end
    end
    i_ack_valid = 1'b0;
    i_ack_stall = 1'b1;
    chk("t2_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) chk($sformatf("t2_order%0d", i), got[i], exp5[i]);
    end

    // issue saturation
    do_reset();
    i_wb_issue = 1'b1;
    repeat (8) step();
    chk("t4_full", {31'd0, o_wb_full}, 32'd1);
    chk("t4_out8", {28'd0, o_outstanding}, 32'd8);
    step();
    i_wb_issue = 1'b0;
    chk("t4_sat", {28'd0, o_outstanding}, 32'd8);
`ifdef L2C_WB_ACK_CHK_EN
    chk("t4_err", {30'd0, o_err}, 32'd2);
`endif

    // issue and pop together at out=3
    do_reset();
    i_wb_issue = 1'b1;
    repeat (3) step();
    i_wb_issue = 1'b0;
    chk("t5_out3", {28'd0, o_outstanding}, 32'd3);
    i_ack_valid = 1'b1;
    i_ack_addr  = 32'hB0;
    step();
    i_ack_valid = 1'b0;
    i_wb_issue  = 1'b1;
    i_ack_stall = 1'b0;
    step();
    i_wb_issue  = 1'b0;
    i_ack_stall = 1'b1;
    chk("t5_out_same", {28'd0, o_outstanding}, 32'd3);
    chk("t5_popped", {31'd0, o_ack_valid}, 32'd0);

    // pop with nothing outstanding
    do_reset();
    i_ack_stall = 1'b0;
    i_ack_valid = 1'b1;
    i_ack_addr  = 32'hB1;
    step();
    i_ack_valid = 1'b0;
    step();
    i_ack_stall = 1'b1;
    chk("t5_zero_valid", {31'd0, o_ack_valid}, 32'd0);
    chk("t5_zero_out", {28'd0, o_outstanding}, 32'd0);
`ifdef L2C_WB_ACK_CHK_EN
    chk("t5_err", {30'd0, o_err}, 32'd1);
`endif

    // reset mid-operation
    do_reset();
    i_wb_issue = 1'b1;
    repeat (5) step();
    i_wb_issue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_ack_valid = 1'b1;
      i_ack_addr  = 32'hC0 + 32'(i);
      step();
    end
    i_ack_valid = 1'b0;
    chk("t6_pre_out", {28'd0, o_outstanding}, 32'd5);
    chk("t6_pre_valid", {31'd0, o_ack_valid}, 32'd1);
    Reset = 1'b1;
    step();
    chk("t6_valid", {31'd0, o_ack_valid}, 32'd0);
    chk("t6_out", {28'd0, o_outstanding}, 32'd0);
    chk("t6_idle", {31'd0, o_idle}, 32'd1);
`ifdef L2C_WB_ACK_CHK_EN
    chk("t6_err", {30'd0, o_err}, 32'd0);
`endif
    Reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l2c_wb_ack_queue.md
# l2c_wb_ack_queue

Buffers writeback acknowledges returning from the MNI and presents them one at a time to the L2C writeback-ack FSM. It also counts writebacks the L2C has issued but not yet acknowledged. It sits between the MNI ack interface (upstream) and `l2c_wb_ack` (downstream). Its `o_ack_valid` / `i_ack_stall` pair connects directly to that FSM's `i_mni_wb_ack_valid` / `o_mni_wb_ack_stall`.

## Interface
Parameters:
- `DEPTH`, 4: ack FIFO entries; power of 2, ≥2.
- `ADDR_W`, 32: width of the acknowledged line address.
- `MAX_OUT`, 8: maximum outstanding writebacks; ≥1.
- `CNT_W`, 4: width of the outstanding counter; must hold `MAX_OUT`.

Ports (clock and reset: `Clk`; `Reset`, synchronous, active-high):
- `Clk`  in  1  clock
- `Reset`  in  1  synchronous active-high reset
- `i_wb_issue`  in  1  one-cycle pulse: L2C handed one writeback to the MNI
- `i_ack_valid`  in  1  MNI presents a writeback ack
- `i_ack_addr`  in  `ADDR_W`  line address of the presented ack
- `o_ack_stall`  out  1  upstream stall; an ack is accepted only when `i_ack_valid & ~o_ack_stall`
- `o_ack_valid`  out  1  head-of-queue ack available to `l2c_wb_ack`
- `o_ack_addr`  out  `ADDR_W`  head-of-queue line address
- `i_ack_stall`  in  1  downstream stall; head is consumed when `o_ack_valid & ~i_ack_stall`
- `o_outstanding`  out  `CNT_W`  issued-but-unacknowledged writeback count
- `o_wb_full`  out  1  `o_outstanding == MAX_OUT`; issuer must not pulse `i_wb_issue`
- `o_idle`  out  1  queue empty and `o_outstanding == 0`
- `o_err`  out  2  sticky errors {bit1: issue overflow, bit0: unexpected ack}; present only with `L2C_WB_ACK_CHK_EN`

## Operation
- Push: `i_ack_valid & ~o_ack_stall` writes `i_ack_addr` at the write pointer and increments it (wraps modulo `DEPTH`).
- Pop: `o_ack_valid & ~i_ack_stall` increments the read pointer (wraps modulo `DEPTH`).
- Occupancy `cnt` ranges 0..`DEPTH`:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: unchanged
- `o_ack_stall = (cnt == DEPTH)`. There is no bypass: when full, stall stays high even if a pop occurs in that cycle.
- `o_ack_valid = (cnt != 0)`. `o_ack_addr` is the storage entry at the read pointer and is don't-care when `o_ack_valid = 0`.
- Outstanding counter `out`, updated on `i_wb_issue` and pop:
  - issue only: +1, saturating at `MAX_OUT`
  - pop only: −1, saturating at 0
  - issue and pop in the same cycle: unchanged
- Pushes do not affect `out`. The writeback is retired when `l2c_wb_ack` broadcasts (pop), not on arrival.
- `o_idle = (cnt == 0) & (out == 0)`.

## Timing
- Reset values: `cnt`, pointers and `out` are 0; `o_ack_stall`=0, `o_ack_valid`=0, `o_outstanding`=0, `o_wb_full`=0, `o_idle`=1, `o_err`=0. Storage is not reset.
- Push to `o_ack_valid`: 1 cycle. An ack accepted at edge N is visible after edge N.
- Pop takes effect at the edge. The next entry is presented on the following cycle with no bubble.
- With `l2c_wb_ack` downstream, one pop occurs per ≥3 cycles.
- All outputs are decoded from registers only. There is no combinational path from any input to any output.
- `Reset` asserted mid-operation discards all queued acks and the count on the next edge.

## Configuration
- `L2C_WB_ACK_CHK_EN` defined:
  - `o_err[1]` sets on `i_wb_issue` while `out == MAX_OUT`.
  - `o_err[0]` sets on a pop while `out == 0` (the pop itself still proceeds).
  - Both bits are sticky until `Reset`.
  - A simulation-only `$display` reports each error.
- Not defined: `o_err` port and checking logic are absent. Saturation behaviour is identical in both builds.

## Structure
- Shared package `l2c_pkg`: `L2C_WB_ADDR_W`, `L2C_WB_ACK_DEPTH`, `L2C_WB_MAX_OUT`, and the `o_err` bit-index constants.
- One sub-module, `l2c_wb_fifo`: generic synchronous FIFO with storage, pointers and occupancy, exposing full/empty.
- The top level adds the outstanding counter, idle and error logic.

## Test plan
- Reset, then one ack with addr 0x1000 while `i_ack_stall`=1 for 3 cycles → `o_ack_valid`=1 from cycle +1; addr held at 0x1000; pop on the first `i_ack_stall`=0 cycle; `o_ack_valid`=0 next cycle.
- 5 back-to-back acks (0xA0..0xA4), `DEPTH`=4, downstream stalled → first 4 accepted; `o_ack_stall`=1 after the 4th; 0xA4 held upstream. Release → output order 0xA0, 0xA1, 0xA2, 0xA3, 0xA4.
- Full queue with simultaneous push attempt and pop → push rejected; `cnt` becomes 3; stall drops the next cycle.
- 8 `i_wb_issue` pulses → `o_wb_full`=1, `o_outstanding`=8. A 9th pulse leaves the count at 8 and, with CHK_EN, sets `o_err`=2'b10.
- `i_wb_issue` and pop in the same cycle at `out`=3 → `out` stays 3. A pop at `out`=0 → `out` stays 0; `o_err[0]`=1 with CHK_EN.
- `Reset` asserted with 3 acks queued and `out`=5 → next cycle `o_ack_valid`=0, `o_outstanding`=0, `o_idle`=1, `o_err`=0.
